arc4_encrypt: RTL and testbench

- ARC4 encryption engine; the counterpart of the task3 decryption path.
- Reads a length-prefixed plaintext buffer from pt memory and writes the length-prefixed ciphertext to ct memory, using a 24-bit key.
- Drives an external 256x8 S-box memory itself (init, KSA, PRGA), so one S memory instance serves it.
- Sits beside the decrypt datapath under the task top level. It produces the ct_mem images that the decrypt bench consumes.

---
 rtl/arc4_encrypt_if.sv | 29 ++
 rtl/arc4_encrypt.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_arc4_encrypt.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_encrypt_if.sv
// Bus bundle for arc4_encrypt: start/ready handshake, key, and the three
// synchronous-read memory ports (S-box, plaintext, ciphertext).
// master = the encryption engine, slave = the surrounding environment.
interface arc4_encrypt_if #(
  parameter int KEY_BYTES = 3
);
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             s_addr;
  logic [7:0]             s_rddata;
  logic [7:0]             s_wrdata;
  logic                   s_wren;
  logic [7:0]             pt_addr;
  logic [7:0]             pt_rddata;
  logic [7:0]             ct_addr;
  logic [7:0]             ct_wrdata;
  logic                   ct_wren;

  modport master (
    input  en, key, s_rddata, pt_rddata,
    output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );

  modport slave (
    output en, key, s_rddata, pt_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );
endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 encryption engine. Reads a length-prefixed plaintext buffer, writes the
// length-prefixed ciphertext, and drives an external 256x8 S-box memory
// through INIT, KSA and PRGA. All memories are synchronous-read: an address
// is held for one cycle and the data is consumed in the following cycle.
// Optional macro ARC4_DROP_EN: discard DROP_N keystream bytes after KSA.
module arc4_encrypt #(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 256
) (
  input  logic           clk,
  input  logic           rst,
  arc4_encrypt_if.master bus
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  // KSA and PRGA share the read-i / read-j / swap sequence; ph_q picks the
  // flavour (key added to j in KSA, pad read + ct write in PRGA).
  typedef enum logic [3:0] {
    S_IDLE, S_INIT,
    S_RDI, S_SI, S_RDJ, S_SJ, S_WRI, S_WRJ,
    S_RDP, S_PAD, S_CTW,
    S_LRD, S_LWT, S_LWR
  } state_t;

  typedef enum logic [1:0] {PH_KSA, PH_DROP, PH_PRGA} phase_t;

  state_t                 state_q, state_d;
  phase_t                 ph_q, ph_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d, l_q, l_d;
  logic [7:0]             si_q, si_d, sj_q, sj_d;
  logic                   rdy_q, rdy_d;
  logic [7:0]             s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
  logic                   s_wren_q, s_wren_d;
  logic [7:0]             pt_addr_q, pt_addr_d;
  logic [7:0]             ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
  logic                   ct_wren_q, ct_wren_d;
  logic [7:0]             jn;
  logic [7:0]             key_byte [KEY_BYTES];

`ifdef ARC4_DROP_EN
  localparam int DCW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  logic [DCW-1:0] dcnt_q, dcnt_d;
`else
  // DROP_N has no effect without the drop feature.
  logic unused_drop_n;
  assign unused_drop_n = (DROP_N != 0);
`endif

  // Key byte 0 is the most significant byte of the latched key.
  for (genvar b = 0; b < KEY_BYTES; b++) begin : g_kb
    assign key_byte[b] = key_q[8*(KEY_BYTES-1-b) +: 8];
  end

  assign bus.rdy       = rdy_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wrdata  = s_wrdata_q;
  assign bus.s_wren    = s_wren_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.ct_wrdata = ct_wrdata_q;
  assign bus.ct_wren   = ct_wren_q;

  // State and registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ph_q        <= PH_KSA;
      key_q       <= '0;
      kidx_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      l_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      rdy_q       <= 1'b1;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      pt_addr_q   <= '0;
      ct_addr_q   <= '0;
      ct_wrdata_q <= '0;
      ct_wren_q   <= 1'b0;
`ifdef ARC4_DROP_EN
      dcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      key_q       <= key_d;
      kidx_q      <= kidx_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      l_q         <= l_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      rdy_q       <= rdy_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      ct_wren_q   <= ct_wren_d;
`ifdef ARC4_DROP_EN
      dcnt_q      <= dcnt_d;
`endif
    end
  end

  // Next-state logic; write strobes default low so each is a one-cycle pulse.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    key_d       = key_q;
    kidx_d      = kidx_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    l_d         = l_q;
    si_d        = si_q;
    sj_d        = sj_q;
    rdy_d       = rdy_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    ct_wren_d   = 1'b0;
    jn          = '0;
`ifdef ARC4_DROP_EN
    dcnt_d      = dcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.en && rdy_q) begin
          key_d      = bus.key;
          rdy_d      = 1'b0;
          i_d        = 8'd0;
          s_addr_d   = 8'd0;
          s_wrdata_d = 8'd0;
          s_wren_d   = 1'b1;
          state_d    = S_INIT;
        end
      end
      // S[i] = i is being written this cycle.
      S_INIT: begin
        if (i_q == 8'hFF) begin
          i_d      = 8'd0;
          j_d      = 8'd0;
          kidx_d   = '0;
          ph_d     = PH_KSA;
          s_addr_d = 8'd0;
          state_d  = S_RDI;
        end else begin
          i_d        = i_q + 8'd1;
          s_addr_d   = i_q + 8'd1;
          s_wrdata_d = i_q + 8'd1;
          s_wren_d   = 1'b1;
        end
      end
      S_RDI: state_d = S_SI;
      // S[i] arrives; advance j and address S[j].
      S_SI: begin
        jn       = j_q + bus.s_rddata +
                   ((ph_q == PH_KSA) ? key_byte[kidx_q] : 8'h00);
        si_d     = bus.s_rddata;
        j_d      = jn;
        s_addr_d = jn;
        state_d  = S_RDJ;
      end
      S_RDJ: state_d = S_SJ;
      // S[j] arrives; swap writes follow (identical values when i == j).
      S_SJ: begin
        sj_d       = bus.s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = bus.s_rddata;
        s_wren_d   = 1'b1;
        state_d    = S_WRI;
      end
      S_WRI: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        state_d    = S_WRJ;
      end
      S_WRJ: begin
        if (ph_q == PH_KSA) begin
          if (i_q == 8'hFF) begin
`ifdef ARC4_DROP_EN
            ph_d     = PH_DROP;
            i_d      = 8'd1;
            j_d      = 8'd0;
            dcnt_d   = '0;
            s_addr_d = 8'd1;
            state_d  = S_RDI;
`else
            pt_addr_d = 8'd0;
            state_d   = S_LRD;
`endif
          end else begin
            i_d      = i_q + 8'd1;
            s_addr_d = i_q + 8'd1;
            kidx_d   = (kidx_q == KW'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
            state_d  = S_RDI;
          end
        end else begin
          // Swap has landed, so this sum indexes post-swap S.
          s_addr_d = si_q + sj_q;
          state_d  = S_RDP;
        end
      end
      S_RDP: state_d = S_PAD;
      // Pad arrives; pt[k] has been addressed since the start of this byte.
      S_PAD: begin
`ifdef ARC4_DROP_EN
        if (ph_q == PH_DROP) begin
          if (dcnt_q == DCW'(DROP_N-1)) begin
            pt_addr_d = 8'd0;
            state_d   = S_LRD;
          end else begin
            dcnt_d   = dcnt_q + 1'b1;
            i_d      = i_q + 8'd1;
            s_addr_d = i_q + 8'd1;
            state_d  = S_RDI;
          end
        end else
`endif
        begin
          ct_addr_d   = k_q;
          ct_wrdata_d = bus.pt_rddata ^ bus.s_rddata;
          ct_wren_d   = 1'b1;
          state_d     = S_CTW;
        end
      end
      // ct[k] is being written; stop exactly at L so addresses never wrap.
      S_CTW: begin
        if (k_q == l_q) begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          k_d       = k_q + 8'd1;
          pt_addr_d = k_q + 8'd1;
          i_d       = i_q + 8'd1;
          s_addr_d  = i_q + 8'd1;
          state_d   = S_RDI;
        end
      end
      S_LRD: state_d = S_LWT;
      S_LWT: begin
        l_d         = bus.pt_rddata;
        ct_addr_d   = 8'd0;
        ct_wrdata_d = bus.pt_rddata;
        ct_wren_d   = 1'b1;
        state_d     = S_LWR;
      end
      // PRGA restarts from i=j=0; i is pre-incremented to 1 here.
      S_LWR: begin
        if (l_q == 8'd0) begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          ph_d      = PH_PRGA;
          i_d       = 8'd1;
          j_d       = 8'd0;
          k_d       = 8'd1;
          pt_addr_d = 8'd1;
          s_addr_d  = 8'd1;
          state_d   = S_RDI;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboard bench for arc4_encrypt: a software ARC4 model (or fixed
// vectors) queues the expected ct writes when a run is launched; a monitor
// pops and compares on every ct write strobe.
module tb_arc4_encrypt;

  localparam int DROP =
`ifdef ARC4_DROP_EN
    256;
`else
    0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arc4_encrypt_if #(.KEY_BYTES(3)) ifc();
  arc4_encrypt #(.KEY_BYTES(3), .DROP_N(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] smem  [256];
  logic [7:0] ptmem [256];
  logic [7:0] ctmem [256];
  logic [7:0] orig  [256];
  logic [7:0] kv_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] kv_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  // Synchronous-read memories.
  always @(posedge clk) begin
    if (ifc.s_wren) smem[ifc.s_addr] <= ifc.s_wrdata;
    ifc.s_rddata  <= smem[ifc.s_addr];
    ifc.pt_rddata <= ptmem[ifc.pt_addr];
    if (ifc.ct_wren) ctmem[ifc.ct_addr] <= ifc.ct_wrdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Reference ARC4 over the current ptmem image.
  task automatic push_model(input logic [23:0] key);
    int s[256];
    int i, j, t, len;
    logic [7:0] kb;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      kb = key[8*(2-(n%3)) +: 8];
      j = (j + s[n] + int'(kb)) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < DROP; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    len = int'(ptmem[0]);
    push_exp(8'd0, ptmem[0]);
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      push_exp(8'(k), ptmem[8'(k)] ^ 8'(s[(s[i] + s[j]) % 256]));
    end
  endtask

  task automatic load_kv();
    for (int n = 0; n < 10; n++) ptmem[n] = kv_pt[n];
  endtask

  task automatic push_kv();
`ifdef ARC4_DROP_EN
    push_model(24'h4B6579);
`else
    for (int n = 0; n < 10; n++) push_exp(8'(n), kv_ct[n]);
`endif
  endtask

  task automatic start(input logic [23:0] k);
    @(negedge clk);
    ifc.en  = 1'b1;
    ifc.key = k;
    @(negedge clk);
    ifc.en  = 1'b0;
    chk("rdy_after_en", 32'(ifc.rdy), 32'd0);
  endtask

  // Bounded wait for rdy; optionally pulses en mid-run with another key.
  task automatic wait_done(input int len, input bit busy);
    int cyc = 0;
    int lim = 256 + 1536 + 10*len + 16 + 8*DROP;
    while (ifc.rdy !== 1'b1 && cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (busy && cyc == 100) begin
        chk("busy_rdy", 32'(ifc.rdy), 32'd0);
        ifc.en  = 1'b1;
        ifc.key = 24'h123456;
      end else begin
        ifc.en = 1'b0;
      end
    end
    ifc.en = 1'b0;
    chk("done_in_bound", 32'(ifc.rdy), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: every ct write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ifc.rdy && (ifc.ct_wren || ifc.s_wren))
      chk("idle_wr", 32'({ifc.ct_wren, ifc.s_wren}), 32'd0);
    if (!rst && ifc.ct_wren) begin
      if (sb.size() == 0) begin
        chk("ct_extra_addr", 32'(ifc.ct_addr), 32'h100);
      end else begin
        e = sb.pop_front();
        chk("ct_addr", 32'(ifc.ct_addr), 32'(e.a));
        chk("ct_data", 32'(ifc.ct_wrdata), 32'(e.d));
      end
    end
  end

  initial begin
    rst     = 1'b1;
    ifc.en  = 1'b0;
    ifc.key = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(ifc.rdy), 32'd1);
    chk("rst_s_wren", 32'(ifc.s_wren), 32'd0);
    chk("rst_ct_wren", 32'(ifc.ct_wren), 32'd0);
    chk("rst_s_addr", 32'(ifc.s_addr), 32'd0);
    chk("rst_s_wrdata", 32'(ifc.s_wrdata), 32'd0);
    chk("rst_pt_addr", 32'(ifc.pt_addr), 32'd0);
    chk("rst_ct_addr", 32'(ifc.ct_addr), 32'd0);
    chk("rst_ct_wrdata", 32'(ifc.ct_wrdata), 32'd0);
    rst = 1'b0;

    // Known vector.
    load_kv();
    push_kv();
    start(24'h4B6579);
    wait_done(9, 1'b0);

    // Round trip: 53-byte message encrypted, then the ct image re-encrypted.
    ptmem[0] = 8'd53;
    for (int n = 1; n <= 53; n++) ptmem[n] = 8'($urandom_range(0, 255));
    for (int n = 0; n <= 53; n++) orig[n] = ptmem[n];
    push_model(24'h000018);
    start(24'h000018);
    wait_done(53, 1'b0);
    for (int n = 0; n <= 53; n++) ptmem[n] = ctmem[n];
    for (int n = 0; n <= 53; n++) push_exp(8'(n), orig[n]);
    start(24'h000018);
    wait_done(53, 1'b0);

    // Empty message: a single ct[0]=0 write.
    ptmem[0] = 8'd0;
    push_exp(8'd0, 8'd0);
    start(24'h4B6579);
    wait_done(0, 1'b0);

    // en while busy is ignored.
    load_kv();
    push_kv();
    start(24'h4B6579);
    wait_done(9, 1'b1);

    // Reset during KSA, then a clean restart.
    load_kv();
    start(24'h4B6579);
    repeat (400) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rdy", 32'(ifc.rdy), 32'd1);
    sb.delete();
    repeat (5) begin
      @(negedge clk);
      chk("midrst_quiet", 32'({ifc.ct_wren, ifc.s_wren}), 32'd0);
    end
    push_kv();
    start(24'h4B6579);
    wait_done(9, 1'b0);

    // Maximum length: addresses 1..255, no wrap to 0.
    ptmem[0] = 8'd255;
    for (int n = 1; n < 256; n++) ptmem[n] = 8'($urandom_range(0, 255));
    push_model(24'hA5C3F0);
    start(24'hA5C3F0);
    wait_done(255, 1'b0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
